core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Run-control FSM that sequences the single-cycle-ALU / multi-cycle-memory core inside TopLevel.
//  Turns the one-cycle start pulse into fetch/execute/memory phases, drives the PC and the
//  per-phase enables, and raises halt on a halt instruction or a watchdog timeout.
//  The bench starts a program with start, then waits on halt.
// PARAMETERS
//  PC_W        10  program-counter width; PC wraps modulo 2**PC_W
//  START_ADDR  0   PC loaded on every start
//  CYC_W       16  width of cycle_count and instr_count
//  MAX_CYCLES  0   watchdog limit in active cycles; 0 = watchdog disabled
// PORTS
//  CLK            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low (0 = reset)
//  start          in   1      run request, sampled each edge
//  halt_instr     in   1      decoder: current instruction is HALT (valid in EXEC)
//  is_mem         in   1      decoder: current instruction is load/store (valid in EXEC)
//  mem_ready      in   1      data memory done (valid in MEM)
//  branch_taken   in   1      branch resolved taken (valid on retire cycle)
//  branch_target  in   PC_W   branch destination
//  pc             out  PC_W   instruction address, registered
//  ir_load        out  1      load instruction register this cycle
//  exec_en        out  1      commit (register/flag write) this cycle
//  mem_req        out  1      data memory access in progress
//  halt           out  1      program finished, registered
//  timeout        out  1      halt was caused by watchdog, registered
//  cycle_count    out  CYC_W  active cycles since last start, saturating
//  instr_count    out  CYC_W  instructions retired since last start, saturating
// BEHAVIOUR
//  - States: IDLE, FETCH, EXEC, MEM, HALTED. reset=0 -> IDLE, pc=START_ADDR, halt=timeout=0,
//    counters=0, all enables 0, immediately (async), including mid-instruction.
//  - IDLE: start=1 -> FETCH; pc<=START_ADDR; counters and timeout cleared.
//  - FETCH: ir_load=1 (Moore), -> EXEC next edge.
//  - EXEC: is_mem=1 -> MEM (exec_en=0). halt_instr=1 -> HALTED, halt<=1, exec_en=0.
//    Otherwise retire: exec_en=1, -> FETCH. halt_instr has priority over is_mem.
//  - MEM: mem_req=1 (Moore). mem_ready=0 -> stay. mem_ready=1 -> retire: exec_en=1, -> FETCH.
//  - Retire (EXEC non-mem, MEM+ready): pc<=branch_taken ? branch_target : pc+1 (wraps);
//    instr_count+1. HALT counts as retired; pc stays on the HALT address.
//  - Latency: ALU/branch instruction 2 cycles; memory instruction 3 + wait cycles.
//  - cycle_count +1 every cycle in FETCH/EXEC/MEM; both counters saturate at all-ones.
//  - Watchdog: MAX_CYCLES!=0 and cycle_count reaches MAX_CYCLES -> HALTED, halt<=1,
//    timeout<=1, no retire that cycle; watchdog has priority over every other transition.
//  - HALTED: halt held 1. start=1 -> FETCH, pc<=START_ADDR, halt/timeout/counters cleared same edge.
//  - start ignored in FETCH/EXEC/MEM; start held high re-launches only from IDLE/HALTED.
//  - Exactly one of ir_load/mem_req/exec_en may be asserted at a time (exec_en with mem_req only
//    on the MEM+mem_ready cycle); verify as assertion.
// STRUCTURE
//  - core_seq_pkg: state_t enum {IDLE,FETCH,EXEC,MEM,HALTED}, default PC_W/CYC_W constants.
//  - One sub-module: sat_counter #(W) (clear, inc, saturating) instanced for both counters.
//  - FSM, PC register and output decode stay in core_sequencer.
// TESTING
//  1 reset=0 during MEM with mem_req=1 -> next sample: mem_req=0, pc=START_ADDR, halt=0, state IDLE.
//  2 start pulse, three ALU instrs then halt_instr -> pc 0,1,2,3; halt=1 after 8 active cycles;
//    instr_count=4, cycle_count=8, timeout=0.
//  3 load with mem_ready low 3 cycles -> mem_req high 4 cycles, exec_en only on ready cycle,
//    pc +1 afterwards, cycle_count=6 for that instruction.
//  4 branch_taken with target 0x3F0 -> pc=0x3F0; straight-line from 0x3FF -> pc=0x000 (PC_W=10).
//  5 MAX_CYCLES=20, branch-to-self loop -> halt=1, timeout=1, cycle_count=20, instr_count=9.
//  6 start during EXEC ignored; start in HALTED -> pc=START_ADDR, halt=0, counters 0 next edge.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and default widths for the core run-control sequencer.
// Used by core_sequencer and its counter sub-module.
package core_seq_pkg;

    localparam int unsigned DEF_PC_W  = 10;
    localparam int unsigned DEF_CYC_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALTED = 3'd4
    } state_t;

    // States in which the core is running a program and the cycle counter advances.
    function automatic logic is_active(input state_t s);
        return (s == FETCH) || (s == EXEC) || (s == MEM);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Clear takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/core_sequencer.sv
// Run-control FSM for the core: sequences fetch/execute/memory phases, owns the PC,
// and halts on a HALT instruction or when the optional watchdog expires.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned PC_W       = DEF_PC_W,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CYC_W      = DEF_CYC_W,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_instr,
    input  logic             is_mem,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             exec_en,
    output logic             mem_req,
    output logic             halt,
    output logic             timeout,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] instr_count
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halt_q, halt_d;
    logic            timeout_q, timeout_d;

    logic            active;
    logic            launch;
    logic            wd_fire;
    logic            commit;
    logic            halt_retire;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] ins_cnt;

    assign active = is_active(state_q);
    assign launch = ((state_q == IDLE) || (state_q == HALTED)) && start;

    // The watchdog fires on the cycle whose count reaches the limit, so that cycle is
    // still counted but never retires.
    generate
        if (MAX_CYCLES != 0) begin : g_wd
            assign wd_fire = active && (cyc_cnt == CYC_W'(MAX_CYCLES - 1));
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halt_d      = halt_q;
        timeout_d   = timeout_q;
        commit      = 1'b0;
        halt_retire = 1'b0;

        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = FETCH;
                    pc_d      = PC_W'(START_ADDR);
                    halt_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            FETCH: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (halt_instr) begin
                    state_d     = HALTED;
                    halt_d      = 1'b1;
                    halt_retire = 1'b1;
                end else if (is_mem) begin
                    state_d = MEM;
                end else begin
                    commit  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    commit  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            pc_d = branch_taken ? branch_target : pc_q + PC_W'(1);
        end

        if (wd_fire) begin
            state_d     = HALTED;
            pc_d        = pc_q;
            halt_d      = 1'b1;
            timeout_d   = 1'b1;
            commit      = 1'b0;
            halt_retire = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= PC_W'(START_ADDR);
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            halt_q    <= halt_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(
        .W (CYC_W)
    ) u_cycle_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .clr   (launch),
        .inc   (active),
        .count (cyc_cnt)
    );

    // HALT counts as a retired instruction even though it does not commit.
    sat_counter #(
        .W (CYC_W)
    ) u_instr_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .clr   (launch),
        .inc   (commit | halt_retire),
        .count (ins_cnt)
    );

    assign pc          = pc_q;
    assign ir_load     = (state_q == FETCH);
    assign mem_req     = (state_q == MEM);
    assign exec_en     = commit;
    assign halt        = halt_q;
    assign timeout     = timeout_q;
    assign cycle_count = cyc_cnt;
    assign instr_count = ins_cnt;

    a_one_phase: assert property (@(posedge CLK) disable iff (!reset)
        !(ir_load && (mem_req || exec_en)) && !(exec_en && mem_req && !mem_ready));

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against an instruction-level reference model.
// A second instance with a 20-cycle watchdog covers the timeout path.
module tb_core_sequencer;

    localparam int unsigned PC_W     = 10;
    localparam int unsigned CYC_W    = 16;
    localparam int unsigned START    = 0;
    localparam int unsigned WD_START = 16;
    localparam int unsigned WD_MAX   = 20;
    localparam int unsigned PC_MASK  = (1 << PC_W) - 1;
    localparam int unsigned CYC_MAX  = (1 << CYC_W) - 1;

    localparam int K_ALU  = 0;
    localparam int K_BR   = 1;
    localparam int K_MEM  = 2;
    localparam int K_HALT = 3;

    logic CLK = 1'b0;
    logic reset = 1'b0;

    logic            start, halt_instr, is_mem, mem_ready, branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] pc;
    logic            ir_load, exec_en, mem_req, halt, timeout;
    logic [CYC_W-1:0] cycle_count, instr_count;

    logic            w_start, w_halt_instr, w_is_mem, w_mem_ready, w_branch_taken;
    logic [PC_W-1:0] w_branch_target;
    logic [PC_W-1:0] w_pc;
    logic            w_ir_load, w_exec_en, w_mem_req, w_halt, w_timeout;
    logic [CYC_W-1:0] w_cycle_count, w_instr_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: PC, active cycles and retired instructions since start.
    int unsigned m_pc, m_cyc, m_ins;

    always #5 CLK = ~CLK;

    core_sequencer #(
        .PC_W       (PC_W),
        .START_ADDR (START),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (0)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .halt_instr    (halt_instr),
        .is_mem        (is_mem),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .ir_load       (ir_load),
        .exec_en       (exec_en),
        .mem_req       (mem_req),
        .halt          (halt),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
    );

    core_sequencer #(
        .PC_W       (PC_W),
        .START_ADDR (WD_START),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (WD_MAX)
    ) dut_wd (
        .CLK           (CLK),
        .reset         (reset),
        .start         (w_start),
        .halt_instr    (w_halt_instr),
        .is_mem        (w_is_mem),
        .mem_ready     (w_mem_ready),
        .branch_taken  (w_branch_taken),
        .branch_target (w_branch_target),
        .pc            (w_pc),
        .ir_load       (w_ir_load),
        .exec_en       (w_exec_en),
        .mem_req       (w_mem_req),
        .halt          (w_halt),
        .timeout       (w_timeout),
        .cycle_count   (w_cycle_count),
        .instr_count   (w_instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CYC_MAX) ? v : v + 1;
    endfunction

    function automatic logic pick_start(input int smode);
        if (smode == 2) return 1'b1;
        if (smode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        start         = 1'b0;
        halt_instr    = 1'b0;
        is_mem        = 1'b0;
        mem_ready     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
    endtask

    task automatic launch();
        @(negedge CLK);
        clear_inputs();
        start = 1'b1;
        #1;
        check("launch_enables", {29'd0, ir_load, mem_req, exec_en}, 0);
        m_pc  = START;
        m_cyc = 0;
        m_ins = 0;
    endtask

    task automatic idle_cycles(input int n, input logic exp_halt);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            clear_inputs();
            #1;
            check("idle_halt", halt, exp_halt);
            check("idle_enables", {29'd0, ir_load, mem_req, exec_en}, 0);
            check("idle_pc", pc, m_pc);
        end
    endtask

    // Runs one instruction through the DUT, checking every cycle against the model.
    task automatic run_instr(input int kind, input int waits, input logic taken,
                             input int unsigned tgt, input int smode);
        @(negedge CLK);
        clear_inputs();
        start = pick_start(smode);
        #1;
        check("fetch_ir_load", ir_load, 1);
        check("fetch_pc", pc, m_pc);
        check("fetch_cycles", cycle_count, m_cyc);
        check("fetch_instrs", instr_count, m_ins);
        check("fetch_halt_timeout", {30'd0, halt, timeout}, 0);
        check("fetch_excl", {30'd0, mem_req, exec_en}, 0);
        m_cyc = sat_inc(m_cyc);

        @(negedge CLK);
        clear_inputs();
        start         = pick_start(smode);
        halt_instr    = (kind == K_HALT);
        is_mem        = (kind == K_MEM) || ((kind == K_HALT) && ($urandom_range(0, 1) == 1));
        branch_taken  = taken;
        branch_target = PC_W'(tgt);
        #1;
        check("exec_ir_load", ir_load, 0);
        check("exec_mem_req", mem_req, 0);
        check("exec_en", exec_en, (kind == K_ALU) || (kind == K_BR));
        check("exec_pc", pc, m_pc);
        m_cyc = sat_inc(m_cyc);

        if (kind == K_MEM) begin
            for (int w = 0; w <= waits; w++) begin
                @(negedge CLK);
                clear_inputs();
                start         = pick_start(smode);
                mem_ready     = (w == waits);
                branch_taken  = taken;
                branch_target = PC_W'(tgt);
                #1;
                check("mem_req", mem_req, 1);
                check("mem_exec_en", exec_en, (w == waits));
                check("mem_ir_load", ir_load, 0);
                check("mem_pc", pc, m_pc);
                m_cyc = sat_inc(m_cyc);
            end
        end

        m_ins = sat_inc(m_ins);
        if (kind != K_HALT) begin
            m_pc = taken ? (tgt & PC_MASK) : ((m_pc + 1) & PC_MASK);
        end else begin
            @(negedge CLK);
            clear_inputs();
            #1;
            check("halt_set", halt, 1);
            check("halt_timeout", timeout, 0);
            check("halt_pc", pc, m_pc);
            check("halt_cycles", cycle_count, m_cyc);
            check("halt_instrs", instr_count, m_ins);
            check("halt_enables", {29'd0, ir_load, mem_req, exec_en}, 0);
        end
    endtask

    initial begin
        int n;
        int kind;
        logic taken;
        logic got_halt;

        clear_inputs();
        w_start = 1'b0; w_halt_instr = 1'b0; w_is_mem = 1'b0; w_mem_ready = 1'b0;
        w_branch_taken = 1'b0; w_branch_target = '0;
        m_pc = START; m_cyc = 0; m_ins = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst_pc", pc, START);
        check("rst_outs", {27'd0, ir_load, mem_req, exec_en, halt, timeout}, 0);
        check("rst_counts", {cycle_count, instr_count}, 0);
        check("rst_wd_pc", w_pc, WD_START);
        @(negedge CLK);
        reset = 1'b1;
        idle_cycles(2, 1'b0);

        // Three ALU instructions then HALT, start held high throughout
        launch();
        for (int i = 0; i < 3; i++) run_instr(K_ALU, 0, 1'b0, 0, 2);
        run_instr(K_HALT, 0, 1'b0, 0, 2);
        check("t2_pc", pc, 3);
        check("t2_cycles", cycle_count, 8);
        check("t2_instrs", instr_count, 4);
        idle_cycles(3, 1'b1);

        // Relaunch from HALTED, then a load with three wait cycles
        launch();
        run_instr(K_ALU, 0, 1'b0, 0, 0);
        run_instr(K_MEM, 3, 1'b0, 0, 1);
        @(posedge CLK);
        #1;
        check("t3_pc", pc, 2);
        check("t3_cycles", cycle_count, 8);
        run_instr(K_HALT, 0, 1'b1, 5, 0);

        // Branch to 0x3F0, then run straight-line across the PC wrap
        launch();
        run_instr(K_BR, 0, 1'b1, 'h3F0, 0);
        for (int i = 0; i < 16; i++) run_instr(K_ALU, 0, 1'b0, 0, 1);
        @(posedge CLK);
        #1;
        check("t4_wrap_pc", pc, 0);
        run_instr(K_HALT, 0, 1'b0, 0, 0);

        // Asynchronous reset in the middle of a memory access
        launch();
        run_instr(K_ALU, 0, 1'b0, 0, 0);
        run_instr(K_ALU, 0, 1'b0, 0, 0);
        @(negedge CLK);
        clear_inputs();
        #1;
        check("t1_fetch", ir_load, 1);
        @(negedge CLK);
        is_mem = 1'b1;
        @(negedge CLK);
        clear_inputs();
        #1;
        check("t1_mem_req_before", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t1_mem_req", mem_req, 0);
        check("t1_pc", pc, START);
        check("t1_halt", halt, 0);
        check("t1_enables", {30'd0, ir_load, exec_en}, 0);
        check("t1_counts", {cycle_count, instr_count}, 0);
        @(negedge CLK);
        reset = 1'b1;
        m_pc = START;
        idle_cycles(3, 1'b0);

        // Random programs ending in HALT, with start noise while running
        for (int p = 0; p < 20; p++) begin
            launch();
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                kind  = $urandom_range(K_ALU, K_MEM);
                taken = (kind == K_BR) || ((kind == K_MEM) && ($urandom_range(0, 3) == 0));
                run_instr(kind, $urandom_range(0, 4), taken, $urandom_range(0, PC_MASK), 1);
            end
            run_instr(K_HALT, 0, 1'($urandom_range(0, 1)), $urandom_range(0, PC_MASK), 1);
            idle_cycles($urandom_range(0, 2), 1'b1);
        end

        // Watchdog: branch-to-self loop on the MAX_CYCLES=20 instance
        @(negedge CLK);
        w_start = 1'b1;
        w_branch_taken = 1'b1;
        w_branch_target = PC_W'(WD_START);
        @(negedge CLK);
        w_start = 1'b0;
        got_halt = 1'b0;
        for (int c = 0; c < 100 && !got_halt; c++) begin
            @(negedge CLK);
            #1;
            got_halt = w_halt;
        end
        check("t5_halt_seen", got_halt, 1);
        check("t5_timeout", w_timeout, 1);
        check("t5_cycles", w_cycle_count, WD_MAX);
        check("t5_instrs", w_instr_count, 9);
        check("t5_pc", w_pc, WD_START);
        check("t5_enables", {29'd0, w_ir_load, w_mem_req, w_exec_en}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
